mdu_controller: RTL and testbench

//  Sequences the multiply/divide unit used by the EX stage of the pipelined MIPS CPU.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_arith.sv | 56 +++++
 rtl/mdu_controller.sv | 120 ++++++++++++
 tb/tb_mdu_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states, counter width.
package mdu_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO arithmetic: returns {hi,lo} for one op from operands and current {hi,lo}.
// Accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] hilo,
    output logic [63:0] result
);

    // Signed divide on magnitudes so INT_MIN / -1 wraps to INT_MIN with a zero remainder.
    function automatic logic [63:0] sdiv(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] mx, my, q, r, quot, rem;
        mx   = x[31] ? (~x + 32'd1) : x;
        my   = y[31] ? (~y + 32'd1) : y;
        q    = mx / my;
        r    = mx % my;
        quot = (x[31] ^ y[31]) ? (~q + 32'd1) : q;
        rem  = x[31] ? (~r + 32'd1) : r;
        return {rem, quot};
    endfunction

    logic signed [63:0] sa64, sb64, sprod;
    logic        [63:0] uprod, sdiv_res, udiv_res;
    logic        [31:0] b_nz;

    assign sa64  = {{32{a[31]}}, a};
    assign sb64  = {{32{b[31]}}, b};
    assign sprod = sa64 * sb64;
    assign uprod = {32'd0, a} * {32'd0, b};

    // Divisor forced non-zero so the unused quotient path stays defined; zero is handled below.
    assign b_nz     = (b == 32'd0) ? 32'd1 : b;
    assign sdiv_res = sdiv(a, b_nz);
    assign udiv_res = {a % b_nz, a / b_nz};

    always_comb begin
        result = hilo;
        case (op)
            OP_MULT:  result = sprod;
            OP_MULTU: result = uprod;
            OP_DIV:   result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : sdiv_res;
            OP_DIVU:  result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : udiv_res;
`ifdef MDU_MADD_EN
            OP_MADD:  result = hilo + sprod;
            OP_MADDU: result = hilo + uprod;
            OP_MSUB:  result = hilo - sprod;
            OP_MSUBU: result = hilo - uprod;
`endif
            default:  result = hilo;
        endcase
    end

endmodule

// File: rtl/mdu_controller.sv
// Multiply/divide sequencer for the EX stage: fixed-latency counter, pending result, HI/LO commit.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
module mdu_controller
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    function automatic logic is_arith(input logic [3:0] o);
        case (o)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_mult(input logic [3:0] o);
        case (o)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             load_p0, commit, wr_hi, wr_lo;
    logic [63:0]      res_p0, res_p1;

    mdu_arith u_arith (
        .op     (op),
        .a      (rs),
        .b      (rt),
        .hilo   ({hi, lo}),
        .result (res_p0)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_p0 = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel) begin
                    if (op == OP_MTHI) begin
                        wr_hi = 1'b1;
                    end else if (op == OP_MTLO) begin
                        wr_lo = 1'b1;
                    end else if (is_arith(op)) begin
                        load_p0 = 1'b1;
                        state_d = S_RUN;
                        count_d = is_mult(op) ? MULT_LOAD : DIV_LOAD;
                    end
                end
            end
            S_RUN: begin
                // cancel wins over a commit falling in the same cycle
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (count_q == '0) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage p0 -> p1: control, done pulse and architectural HI/LO
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done    <= commit;
            if (commit) begin
                {hi, lo} <= res_p1;
            end else begin
                if (wr_hi) hi <= rs;
                if (wr_lo) lo <= rs;
            end
        end
    end

    // Stage p0 -> p1: pending result captured at start
    always_ff @(posedge clk) begin
        if (load_p0) res_p1 <= res_p0;
    end

    assign busy = (state_q == S_RUN);

endmodule

// File: tb/tb_mdu_controller.sv
// Directed self-checking bench for mdu_controller; expected values are hand-computed constants.
module tb_mdu_controller;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        cancel;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    int          cyc;
    logic        dfall, dafter;
    logic [31:0] hfall, lfall;

    mdu_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Launch one op, scramble operands afterwards, count busy cycles (bounded).
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int n, output logic d_fall, output logic d_after,
                          output logic [31:0] h_fall, output logic [31:0] l_fall);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; op = OP_NONE; rs = $urandom; rt = $urandom;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        d_fall = done; h_fall = hi; l_fall = lo;
        @(negedge clk);
        d_after = done;
    endtask

    task automatic pulse_reset;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        reset = 1'b1;
    endtask

    task automatic test_mult;
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, cyc, dfall, dafter, hfall, lfall);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", cyc); end
        checks++; if (dfall !== 1'b1) begin errors++; $display("FAIL mult_done_pulse: got %b expected 1", dfall); end
        checks++; if (dafter !== 1'b0) begin errors++; $display("FAIL mult_done_single: got %b expected 0", dafter); end
        checks++; if (hfall !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hfall); end
        checks++; if (lfall !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", lfall); end
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, cyc, dfall, dafter, hfall, lfall);
        checks++; if (hfall !== 32'h4000_0000) begin errors++; $display("FAIL mult_min_hi: got %h expected 40000000", hfall); end
        checks++; if (lfall !== 32'h0) begin errors++; $display("FAIL mult_min_lo: got %h expected 0", lfall); end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, dfall, dafter, hfall, lfall);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 5", cyc); end
        checks++; if (hfall !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", hfall); end
        checks++; if (lfall !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 1", lfall); end
    endtask

    task automatic test_div;
        run_op(OP_DIVU, 32'd100, 32'd7, cyc, dfall, dafter, hfall, lfall);
        checks++; if (cyc !== 10) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected 10", cyc); end
        checks++; if (dfall !== 1'b1) begin errors++; $display("FAIL divu_done: got %b expected 1", dfall); end
        checks++; if (lfall !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected e", lfall); end
        checks++; if (hfall !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 2", hfall); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc, dfall, dafter, hfall, lfall);
        checks++; if (lfall !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected fffffffd", lfall); end
        checks++; if (hfall !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected ffffffff", hfall); end
    endtask

    task automatic test_div_edge;
        run_op(OP_DIV, 32'd5, 32'd0, cyc, dfall, dafter, hfall, lfall);
        checks++; if (lfall !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", lfall); end
        checks++; if (hfall !== 32'd5) begin errors++; $display("FAIL div0_hi: got %h expected 5", hfall); end
        run_op(OP_DIVU, 32'h20, 32'd0, cyc, dfall, dafter, hfall, lfall);
        checks++; if (lfall !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo: got %h expected ffffffff", lfall); end
        checks++; if (hfall !== 32'h20) begin errors++; $display("FAIL divu0_hi: got %h expected 20", hfall); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dfall, dafter, hfall, lfall);
        checks++; if (lfall !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lfall); end
        checks++; if (hfall !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 0", hfall); end
    endtask

    task automatic test_cancel;
        logic seen_done;
        pulse_reset;
        @(negedge clk); start = 1'b1; op = OP_MULT; rs = 32'd3; rt = 32'd4;
        @(negedge clk); start = 1'b0; op = OP_NONE;
        @(negedge clk);
        @(negedge clk); cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cancel_done: got %b expected 0", done); end
        seen_done = 1'b0;
        repeat (8) begin @(negedge clk); if (done === 1'b1) seen_done = 1'b1; end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL cancel_late_done: got %b expected 0", seen_done); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL cancel_lo: got %h expected 0", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL cancel_hi: got %h expected 0", hi); end
        // cancel on the final RUN cycle must still beat the commit
        @(negedge clk); start = 1'b1; op = OP_MULT; rs = 32'd3; rt = 32'd4;
        @(negedge clk); start = 1'b0; op = OP_NONE;
        repeat (3) @(negedge clk);
        @(negedge clk); cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_last_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cancel_last_done: got %b expected 0", done); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL cancel_last_lo: got %h expected 0", lo); end
        @(negedge clk); start = 1'b1; cancel = 1'b1; op = OP_MTLO; rs = 32'd9;
        @(negedge clk); start = 1'b0; cancel = 1'b0; op = OP_NONE;
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL start_cancel_mtlo: got %h expected 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_cancel_busy: got %b expected 0", busy); end
    endtask

    task automatic test_move_and_ignore;
        @(negedge clk); start = 1'b1; op = OP_MTHI; rs = 32'h1234;
        @(negedge clk); start = 1'b0; op = OP_NONE;
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h expected 1234", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mthi_done: got %b expected 0", done); end
        @(negedge clk); start = 1'b1; op = 4'hF; rs = 32'hAAAA; rt = 32'h5;
        @(negedge clk); start = 1'b0; op = OP_NONE;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL undef_op_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL undef_op_hi: got %h expected 1234", hi); end
        // start during RUN is dropped, and the DIVU result is unaffected
        @(negedge clk); start = 1'b1; op = OP_DIVU; rs = 32'd50; rt = 32'd8;
        @(negedge clk); op = OP_MTHI; rs = 32'hDEAD;
        @(negedge clk); start = 1'b0; op = OP_NONE;
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL start_in_run_hi: got %h expected 1234", hi); end
        repeat (10) @(negedge clk);
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL start_in_run_lo: got %h expected 6", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL start_in_run_rem: got %h expected 2", hi); end
    endtask

    task automatic test_reset_mid_run;
        logic seen_done;
        @(negedge clk); start = 1'b1; op = OP_DIV; rs = 32'd100; rt = 32'd7;
        @(negedge clk); start = 1'b0; op = OP_NONE;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rst_mid_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rst_mid_lo: got %h expected 0", lo); end
        seen_done = 1'b0;
        repeat (12) begin @(negedge clk); if (done === 1'b1) seen_done = 1'b1; end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rst_mid_late_done: got %b expected 0", seen_done); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL rst_mid_late_lo: got %h expected 0", lo); end
    endtask

    task automatic test_madd;
        @(negedge clk); start = 1'b1; op = OP_MTLO; rs = 32'hFFFF_FFFF;
        @(negedge clk); start = 1'b0; op = OP_NONE;
`ifdef MDU_MADD_EN
        run_op(OP_MADDU, 32'd1, 32'd1, cyc, dfall, dafter, hfall, lfall);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL maddu_busy_cycles: got %0d expected 5", cyc); end
        checks++; if (hfall !== 32'd1) begin errors++; $display("FAIL maddu_hi: got %h expected 1", hfall); end
        checks++; if (lfall !== 32'd0) begin errors++; $display("FAIL maddu_lo: got %h expected 0", lfall); end
`else
        @(negedge clk); start = 1'b1; op = OP_MADDU; rs = 32'd1; rt = 32'd1;
        @(negedge clk); start = 1'b0; op = OP_NONE;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL maddu_off_busy: got %b expected 0", busy); end
        repeat (6) @(negedge clk);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL maddu_off_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL maddu_off_lo: got %h expected ffffffff", lo); end
`endif
    endtask

    initial begin
        start = 1'b0; cancel = 1'b0; op = OP_NONE; rs = '0; rt = '0; reset = 1'b0;
        test_reset;
        test_mult;
        test_div;
        test_div_edge;
        test_cancel;
        test_move_and_ignore;
        test_reset_mid_run;
        test_madd;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
